// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state type and count width for the count sequencer
package count_seq_pkg;
  localparam int COUNT_W = 8;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} stateT;
endpackage

// File: rtl/count_seq_if.sv
// count_seq_if: link between the sequencer and the 8-bit counter it drives
interface count_seq_if;
  import count_seq_pkg::*;
  logic [COUNT_W-1:0] CounterValue;
  logic CounterEnable;
  logic CounterClear;
  modport master(input CounterValue, output CounterEnable, output CounterClear);
  modport slave(output CounterValue, input CounterEnable, input CounterClear);
endinterface

// File: rtl/count_seq_rate_div.sv
// count_seq_rate_div: loadable down-counter that sets the spacing of enable pulses
module count_seq_rate_div #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Load,
  input  logic         Freeze,
  input  logic [W-1:0] LoadValue,
  output logic         Zero
);
  logic [W-1:0] count;
  always_ff @(posedge Clock)
    if (Reset) count <= '0;
    else if (Load) count <= LoadValue;
    else if (!Freeze && count != '0) count <= count - W'(1);
  assign Zero = count == '0;
endmodule

// File: rtl/count_seq.sv
// count_seq: sequences an external 8-bit counter up to a limit; COUNT_SEQ_PAUSE_EN enables Pause
module count_seq import count_seq_pkg::*; #(
  parameter int DIV_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic               Pause,
  input  logic               Continuous,
  input  logic [COUNT_W-1:0] Limit,
  input  logic [DIV_W-1:0]   Period,
  count_seq_if.master        ctr,
  output logic               Busy,
  output logic               Done,
  output logic               Wrap
);
  stateT state, nextState;
  logic [COUNT_W-1:0] limitReg;
  logic [DIV_W-1:0] periodReg;
  logic contReg, divLoad, divFreeze, divZero, pauseReq, start, atLimit;
`ifdef COUNT_SEQ_PAUSE_EN
  assign pauseReq = Pause;
`else
  logic unusedPause;
  assign unusedPause = Pause;
  assign pauseReq = 1'b0;
`endif
  assign start = state == IDLE && Start && !Stop;
  assign atLimit = ctr.CounterValue == limitReg;
  always_ff @(posedge Clock)
    if (Reset) begin
      state <= IDLE;
      limitReg <= '0;
      periodReg <= '0;
      contReg <= 1'b0;
    end else begin
      state <= nextState;
      if (start) begin
        limitReg <= Limit;
        periodReg <= Period;
        contReg <= Continuous;
      end
    end
  // the limit check wins over a due pulse so the counter never overshoots
  always_comb begin
    nextState = state;
    ctr.CounterEnable = 1'b0;
    Wrap = 1'b0;
    divLoad = 1'b0;
    divFreeze = 1'b1;
    case (state)
      IDLE: nextState = start ? CLEAR : IDLE;
      CLEAR: begin
        nextState = Stop ? IDLE : RUN;
        divLoad = 1'b1;
      end
      RUN:
        if (Stop) nextState = IDLE;
        else if (pauseReq) nextState = PAUSE;
        else if (atLimit) begin
          nextState = contReg ? CLEAR : DONE;
          Wrap = contReg;
        end else begin
          divFreeze = 1'b0;
          ctr.CounterEnable = divZero;
          divLoad = divZero;
        end
      PAUSE: nextState = Stop ? IDLE : (pauseReq ? PAUSE : RUN);
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end
  assign Done = state == DONE && !Stop;
  assign ctr.CounterClear = state == CLEAR;
  assign Busy = state != IDLE;
  count_seq_rate_div #(.W(DIV_W)) rateDiv (
    .Clock(Clock),
    .Reset(Reset),
    .Load(divLoad),
    .Freeze(divFreeze),
    .LoadValue(periodReg),
    .Zero(divZero)
  );
endmodule

// File: doc/count_seq.md
COUNT_SEQ -- requirements
Module: count_seq

Interface
REQ-001 The block SHALL have parameter DIV_W, default 4, which sets the rate-divider period width in bits (minimum 1).
REQ-002 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Start, input, 1 bit: begin a count run; sampled only in IDLE.
REQ-005 The block SHALL have port Stop, input, 1 bit: abort the run from any non-IDLE state.
REQ-006 The block SHALL have port Pause, input, 1 bit: hold the run; used only when COUNT_SEQ_PAUSE_EN is defined.
REQ-007 The block SHALL have port Continuous, input, 1 bit: 0 selects one-shot, 1 selects auto-restart at limit.
REQ-008 The block SHALL have port Limit, input, 8 bits: terminal count value.
REQ-009 The block SHALL have port Period, input, DIV_W bits: clocks between enable pulses, minus 1.
REQ-010 The block SHALL have port CounterValue, input, 8 bits: current value of the 8-bit enable counter being sequenced.
REQ-011 The block SHALL have port CounterEnable, output, 1 bit: increment strobe to the counter's Enable.
REQ-012 The block SHALL have port CounterClear, output, 1 bit: drives the counter's synchronous clear.
REQ-013 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have ports Done and Wrap, outputs, 1 bit each: one-cycle pulses for one-shot completion and continuous wrap.

Function
REQ-015 The block SHALL implement states IDLE, CLEAR, RUN, PAUSE and DONE.
REQ-016 In IDLE with Start=1 and Stop=0, the block SHALL register Limit, Period and Continuous and go to CLEAR; these inputs SHALL be ignored at all other times.
REQ-017 CLEAR SHALL last exactly 1 cycle, SHALL assert CounterClear, SHALL load the divider with the registered Period, and SHALL then go to RUN.
REQ-018 In RUN, when the divider is 0 and CounterValue != registered Limit, the block SHALL assert CounterEnable for 1 cycle and reload the divider with Period; otherwise the divider SHALL decrement by 1 when nonzero.
REQ-019 With Period=P, consecutive CounterEnable pulses SHALL be exactly P+1 cycles apart, and the first pulse SHALL come P+1 cycles after CLEAR.
REQ-020 In RUN, when CounterValue == registered Limit, the block SHALL issue no CounterEnable and SHALL go to DONE (one-shot) or to CLEAR with Wrap=1 for that cycle (continuous); there SHALL be no overshoot past Limit.
REQ-021 With Limit=0, the block SHALL pass through CLEAR then RUN then DONE/CLEAR and SHALL issue zero enables.
REQ-022 DONE SHALL last 1 cycle with Done=1 and then go to IDLE.
REQ-023 Stop=1 in CLEAR, RUN, PAUSE or DONE SHALL force IDLE on the next edge with no Done or Wrap pulse and no CounterEnable in that cycle.
REQ-024 Start and Stop asserted together in IDLE SHALL leave the block in IDLE.
REQ-025 Start asserted while Busy=1 SHALL be ignored.

Reset
REQ-026 Reset=1 SHALL take priority over all inputs and SHALL force IDLE, divider=0, all registered settings=0, and CounterEnable, CounterClear, Busy, Done and Wrap all low on the next edge, including when a run is in progress.

Configuration
REQ-027 The macro COUNT_SEQ_PAUSE_EN SHALL control the pause feature.
REQ-028 With COUNT_SEQ_PAUSE_EN defined, Pause=1 in RUN SHALL enter PAUSE with divider frozen and no enables, and Pause=0 in PAUSE SHALL return to RUN with the divider resuming from its frozen value; Stop SHALL take priority over Pause.
REQ-029 With COUNT_SEQ_PAUSE_EN undefined, the Pause port SHALL remain present but ignored, and the PAUSE state SHALL be unreachable.

Structure
REQ-030 The package count_seq_pkg SHALL hold the state enum type and the 8-bit count width constant.
REQ-031 The divider SHALL be the sub-module count_seq_rate_div (load, decrement, zero flag, freeze input).

Verification
REQ-032 Bench case, one-shot: Limit=5, Period=0 -> 1 clear cycle, then 5 consecutive enables, counter reaches 5, Done pulse, Busy low the following cycle.
REQ-033 Bench case, rate: Limit=3, Period=3 -> enables spaced exactly 4 cycles, exactly 3 enables, final value 3.
REQ-034 Bench case, continuous: Limit=2, Period=0 -> repeating sequence 0,1,2, with Wrap and CounterClear pulsing once per wrap and Done never asserted.
REQ-035 Bench case, Stop: Stop asserted at counter value 2 of a Limit=6 run -> IDLE next cycle, counter held at 2, no Done.
REQ-036 Bench case, reset and Limit=0: Reset mid-run -> all outputs 0 next edge; Start with Limit=0 -> Done with zero enables.
REQ-037 Bench case, pause (COUNT_SEQ_PAUSE_EN): Pause for 5 cycles mid-run -> no enables while paused, pulse spacing intact afterwards.
